// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: ALU select codes, MIPS opcode/funct
// values, error bit positions and the operand-B source selector.
package alu_issue_stage_pkg;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_AND  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_SLT  = 4'd4;
  localparam logic [3:0] SEL_MOVE = 4'd5;
  localparam logic [3:0] SEL_MULT = 4'd6;
  localparam logic [3:0] SEL_DIV  = 4'd7;
  localparam logic [3:0] SEL_BNE  = 4'd8;
  localparam logic [3:0] SEL_BGTZ = 4'd9;
  localparam logic [3:0] SEL_ILL  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_MOVE  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam int unsigned ERR_ILL  = 0;
  localparam int unsigned ERR_DIV0 = 1;

  typedef enum logic [1:0] {EbRt, EbSext, EbZext, EbZero} eb_mode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode to ALU select, operand-B source and error flags.
module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       rt_zero_i,
  output logic [3:0] sel_o,
  output eb_mode_t   eb_mode_o,
  output logic [1:0] err_o
);

  always_comb begin
    sel_o     = SEL_ILL;
    eb_mode_o = EbZero;
    err_o     = '0;
    case (op_i)
      OP_RTYPE: begin
        eb_mode_o = EbRt;
        case (funct_i)
          FN_ADD:  sel_o = SEL_ADD;
          FN_SUB:  sel_o = SEL_SUB;
          FN_AND:  sel_o = SEL_AND;
          FN_OR:   sel_o = SEL_OR;
          FN_SLT:  sel_o = SEL_SLT;
          FN_MOVE: sel_o = SEL_MOVE;
          FN_MULT: sel_o = SEL_MULT;
          FN_DIV:  sel_o = SEL_DIV;
          default: eb_mode_o = EbZero;
        endcase
      end
      OP_ADDI: begin sel_o = SEL_ADD;  eb_mode_o = EbSext; end
      OP_SLTI: begin sel_o = SEL_SLT;  eb_mode_o = EbSext; end
      OP_ANDI: begin sel_o = SEL_AND;  eb_mode_o = EbZext; end
      OP_ORI:  begin sel_o = SEL_OR;   eb_mode_o = EbZext; end
      OP_BEQ:  begin sel_o = SEL_SUB;  eb_mode_o = EbRt;   end
      OP_BNE:  begin sel_o = SEL_BNE;  eb_mode_o = EbRt;   end
      OP_BGTZ: begin sel_o = SEL_BGTZ; eb_mode_o = EbZero; end
      default: ;
    endcase
    err_o[ERR_ILL]  = (sel_o == SEL_ILL);
    err_o[ERR_DIV0] = (sel_o == SEL_DIV) && rt_zero_i;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered operand-issue stage feeding the ALU, with a 2-entry (main + skid)
// buffer so execute-side backpressure never drops an instruction.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [5:0]       in_funct,
  input  logic [DW-1:0]    in_rs_val,
  input  logic [DW-1:0]    in_rt_val,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_EA,
  output logic [DW-1:0]    out_EB,
  output logic [3:0]       out_sel,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] issued_cnt
);

  logic [3:0]    dec_sel;
  eb_mode_t      dec_eb_mode;
  logic [1:0]    dec_err;
  logic [DW-1:0] dec_ea, dec_eb;

  alu_op_decode u_decode (
    .op_i      (in_op),
    .funct_i   (in_funct),
    .rt_zero_i (in_rt_val == '0),
    .sel_o     (dec_sel),
    .eb_mode_o (dec_eb_mode),
    .err_o     (dec_err)
  );

  always_comb begin
    dec_ea = dec_err[ERR_ILL] ? '0 : in_rs_val;
    case (dec_eb_mode)
      EbRt:    dec_eb = in_rt_val;
      EbSext:  dec_eb = {{(DW-16){in_imm[15]}}, in_imm};
      EbZext:  dec_eb = {{(DW-16){1'b0}}, in_imm};
      default: dec_eb = '0;
    endcase
    // Force a non-zero divisor so the ALU never produces an undefined result.
    if (dec_err[ERR_DIV0]) dec_eb = {{(DW-1){1'b0}}, 1'b1};
  end

  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [DW-1:0]    m_ea_q, m_ea_d, m_eb_q, m_eb_d, s_ea_q, s_ea_d, s_eb_q, s_eb_d;
  logic [3:0]       m_sel_q, m_sel_d, s_sel_q, s_sel_d;
  logic [1:0]       m_err_q, m_err_d, s_err_q, s_err_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain;

  always_comb begin
    accept    = in_valid && in_ready_q && !flush;
    drain     = m_valid_q && out_ready;
    m_valid_d = m_valid_q;
    m_ea_d    = m_ea_q;
    m_eb_d    = m_eb_q;
    m_sel_d   = m_sel_q;
    m_err_d   = m_err_q;
    s_valid_d = s_valid_q;
    s_ea_d    = s_ea_q;
    s_eb_d    = s_eb_q;
    s_sel_d   = s_sel_q;
    s_err_d   = s_err_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (s_valid_q) begin
          m_ea_d    = s_ea_q;
          m_eb_d    = s_eb_q;
          m_sel_d   = s_sel_q;
          m_err_d   = s_err_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      // accept implies the skid slot is empty, so it never collides with S->M.
      if (accept) begin
        if (!m_valid_q || drain) begin
          m_valid_d = 1'b1;
          m_ea_d    = dec_ea;
          m_eb_d    = dec_eb;
          m_sel_d   = dec_sel;
          m_err_d   = dec_err;
        end else begin
          s_valid_d = 1'b1;
          s_ea_d    = dec_ea;
          s_eb_d    = dec_eb;
          s_sel_d   = dec_sel;
          s_err_d   = dec_err;
        end
      end
    end
    in_ready_d = !s_valid_d;
    cnt_d      = cnt_q + CNT_W'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_ea_q     <= '0;
      m_eb_q     <= '0;
      m_sel_q    <= '0;
      m_err_q    <= '0;
      s_valid_q  <= 1'b0;
      s_ea_q     <= '0;
      s_eb_q     <= '0;
      s_sel_q    <= '0;
      s_err_q    <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_ea_q     <= m_ea_d;
      m_eb_q     <= m_eb_d;
      m_sel_q    <= m_sel_d;
      m_err_q    <= m_err_d;
      s_valid_q  <= s_valid_d;
      s_ea_q     <= s_ea_d;
      s_eb_q     <= s_eb_d;
      s_sel_q    <= s_sel_d;
      s_err_q    <= s_err_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_valid_q;
  assign out_EA     = m_ea_q;
  assign out_EB     = m_eb_q;
  assign out_sel    = m_sel_q;
  assign out_err    = m_valid_q ? m_err_q : 2'b00;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized
// run against a queue-based reference model of the issue stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_EA, out_EB;
  logic [3:0]  out_sel;
  logic [1:0]  out_err;
  logic [15:0] issued_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [1:0]  err;
  } exp_t;

  logic [5:0] fn_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h18, 6'h1A};
  logic [5:0] op_tab [7] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h07};

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_funct   (in_funct),
    .in_rs_val  (in_rs_val),
    .in_rt_val  (in_rt_val),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_EA     (out_EA),
    .out_EB     (out_EB),
    .out_sel    (out_sel),
    .out_err    (out_err),
    .issued_cnt (issued_cnt)
  );

  // Reference decode straight from the instruction table.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm);
    exp_t r;
    logic [31:0] sx, zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    r.ea = rs; r.eb = rt; r.err = 2'b00; r.sel = 4'hF;
    if (op == 6'h00) begin
      case (fn)
        6'h20: r.sel = 4'd0;
        6'h22: r.sel = 4'd1;
        6'h24: r.sel = 4'd2;
        6'h25: r.sel = 4'd3;
        6'h2A: r.sel = 4'd4;
        6'h21: r.sel = 4'd5;
        6'h18: r.sel = 4'd6;
        6'h1A: r.sel = 4'd7;
        default: r.sel = 4'hF;
      endcase
    end else if (op == 6'h08) begin r.sel = 4'd0; r.eb = sx; end
    else if (op == 6'h0A) begin r.sel = 4'd4; r.eb = sx; end
    else if (op == 6'h0C) begin r.sel = 4'd2; r.eb = zx; end
    else if (op == 6'h0D) begin r.sel = 4'd3; r.eb = zx; end
    else if (op == 6'h04) r.sel = 4'd1;
    else if (op == 6'h05) r.sel = 4'd8;
    else if (op == 6'h07) begin r.sel = 4'd9; r.eb = 32'd0; end
    if (r.sel == 4'hF) begin r.ea = 32'd0; r.eb = 32'd0; r.err = 2'b01; end
    if (r.sel == 4'd7 && rt == 32'd0) begin r.eb = 32'd1; r.err = 2'b10; end
    return r;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm);
    in_op = op; in_funct = fn; in_rs_val = rs; in_rt_val = rt; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if ({out_EA, out_EB, out_sel, out_err} !== 70'd0) begin miscompares++;
      $display("FAIL reset_outputs: EA=%h EB=%h sel=%h err=%b want 0", out_EA, out_EB,
               out_sel, out_err); end
    vectors++; if (issued_cnt !== 16'd0) begin miscompares++;
      $display("FAIL reset_cnt: got %h want 0", issued_cnt); end
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_basic;
    @(negedge clk);
    drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_valid, out_EA, out_EB, out_sel, out_err} !== {1'b1, 32'd5, 32'd7,
        4'd0, 2'b00}) begin miscompares++;
      $display("FAIL basic_add: got v=%b EA=%h EB=%h sel=%h err=%b want 1/5/7/0/00",
               out_valid, out_EA, out_EB, out_sel, out_err); end
    @(negedge clk);
    exp_cnt++;
    vectors++; if (issued_cnt !== 16'd1) begin miscompares++;
      $display("FAIL basic_cnt: got %0d want 1", issued_cnt); end
    vectors++; if ({out_valid, out_err, out_EA} !== {1'b0, 2'b00, 32'd5}) begin
      miscompares++;
      $display("FAIL basic_empty_hold: got v=%b err=%b EA=%h want 0/00/5", out_valid,
               out_err, out_EA); end
  endtask

  task automatic test_imm;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    exp_t e;
    out_ready = 1'b1;
    @(negedge clk);
    drive(6'h08, 6'h00, 32'd3, 32'h1234, 16'hFFFE);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_EA, out_EB, out_sel} !== {32'd3, 32'hFFFFFFFE, 4'd0}) begin
      miscompares++;
      $display("FAIL addi_sext: got EA=%h EB=%h sel=%h want 3/fffffffe/0", out_EA, out_EB,
               out_sel); end
    @(negedge clk);
    exp_cnt++;
    drive(6'h0D, 6'h00, 32'd9, 32'h55, 16'h8001);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_EB, out_sel} !== {32'h00008001, 4'd3}) begin miscompares++;
      $display("FAIL ori_zext: got EB=%h sel=%h want 00008001/3", out_EB, out_sel); end
    @(negedge clk);
    exp_cnt++;
    for (int i = 0; i < 7; i++) begin
      rs = $urandom; rt = $urandom; imm = 16'($urandom);
      e = model(op_tab[i], 6'($urandom), rs, rt, imm);
      drive(op_tab[i], 6'($urandom), rs, rt, imm);
      in_funct = 6'h3F;
      e = model(op_tab[i], 6'h3F, rs, rt, imm);
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_sel, out_EA, out_EB, out_err} !== {e.sel, e.ea, e.eb, e.err})
        begin miscompares++;
        $display("FAIL imm_op_%h: got sel=%h EA=%h EB=%h err=%b want %h/%h/%h/%b",
                 op_tab[i], out_sel, out_EA, out_EB, out_err, e.sel, e.ea, e.eb, e.err);
      end
      @(negedge clk);
      exp_cnt++;
    end
  endtask

  task automatic test_errors;
    out_ready = 1'b1;
    drive(6'h00, 6'h1A, 32'd9, 32'd0, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_sel, out_EA, out_EB, out_err} !== {4'd7, 32'd9, 32'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL div_zero: got sel=%h EA=%h EB=%h err=%b want 7/9/1/10", out_sel,
               out_EA, out_EB, out_err); end
    @(negedge clk);
    exp_cnt++;
    drive(6'h00, 6'h1A, 32'd9, 32'd4, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_EB, out_err} !== {32'd4, 2'b00}) begin miscompares++;
      $display("FAIL div_nonzero: got EB=%h err=%b want 4/00", out_EB, out_err); end
    @(negedge clk);
    exp_cnt++;
    drive(6'h3F, 6'h20, 32'hDEAD, 32'hBEEF, 16'h1);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_sel, out_EA, out_EB, out_err} !== {4'hF, 32'd0, 32'd0, 2'b01}) begin
      miscompares++;
      $display("FAIL illegal_op: got sel=%h EA=%h EB=%h err=%b want f/0/0/01", out_sel,
               out_EA, out_EB, out_err); end
    @(negedge clk);
    exp_cnt++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(6'h00, 6'h20, 32'hA, 32'h1, 16'h0);
    @(negedge clk);
    vectors++; if ({in_ready, out_valid, out_EA} !== {1'b1, 1'b1, 32'hA}) begin
      miscompares++;
      $display("FAIL bp_a_in_m: got rdy=%b v=%b EA=%h want 1/1/a", in_ready, out_valid,
               out_EA); end
    drive(6'h00, 6'h20, 32'hB, 32'h1, 16'h0);
    @(negedge clk);
    vectors++; if ({in_ready, out_EA} !== {1'b0, 32'hA}) begin miscompares++;
      $display("FAIL bp_b_in_s: got rdy=%b EA=%h want 0/a", in_ready, out_EA); end
    drive(6'h00, 6'h20, 32'hC, 32'h1, 16'h0);
    @(negedge clk);
    vectors++; if ({in_ready, out_valid, out_EA} !== {1'b0, 1'b1, 32'hA}) begin
      miscompares++;
      $display("FAIL bp_full_hold: got rdy=%b v=%b EA=%h want 0/1/a", in_ready, out_valid,
               out_EA); end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({in_ready, out_valid, out_EA} !== {1'b1, 1'b1, 32'hB}) begin
      miscompares++;
      $display("FAIL bp_order_b: got rdy=%b v=%b EA=%h want 1/1/b", in_ready, out_valid,
               out_EA); end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if ({out_valid, out_EA} !== {1'b1, 32'hC}) begin miscompares++;
      $display("FAIL bp_order_c: got v=%b EA=%h want 1/c", out_valid, out_EA); end
    @(negedge clk);
    exp_cnt += 16'd3;
    vectors++; if ({out_valid, issued_cnt} !== {1'b0, exp_cnt}) begin miscompares++;
      $display("FAIL bp_drained: got v=%b cnt=%0d want 0/%0d", out_valid, issued_cnt,
               exp_cnt); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(6'h00, 6'h22, 32'h11, 32'h1, 16'h0);
    @(negedge clk);
    drive(6'h00, 6'h22, 32'h22, 32'h1, 16'h0);
    @(negedge clk);
    vectors++; if ({in_ready, out_valid} !== 2'b01) begin miscompares++;
      $display("FAIL flush_pre_full: got rdy=%b v=%b want 0/1", in_ready, out_valid); end
    flush = 1'b1;
    drive(6'h00, 6'h22, 32'h33, 32'h1, 16'h0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++; if ({out_valid, in_ready, out_err, issued_cnt} !== {2'b01, 2'b00, exp_cnt})
      begin miscompares++;
      $display("FAIL flush_clear: got v=%b rdy=%b err=%b cnt=%0d want 0/1/00/%0d",
               out_valid, in_ready, out_err, issued_cnt, exp_cnt); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({out_valid, issued_cnt} !== {1'b0, exp_cnt}) begin miscompares++;
      $display("FAIL flush_nothing_issued: got v=%b cnt=%0d want 0/%0d", out_valid,
               issued_cnt, exp_cnt); end
  endtask

  task automatic test_random;
    exp_t q[$];
    exp_t e;
    int k;
    logic acc, drn;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      vectors++; if (out_valid !== (q.size() > 0)) begin miscompares++;
        $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, q.size() > 0); end
      vectors++; if (in_ready !== (q.size() < 2)) begin miscompares++;
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, q.size() < 2); end
      vectors++; if (issued_cnt !== exp_cnt) begin miscompares++;
        $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, issued_cnt, exp_cnt); end
      if (q.size() > 0) begin
        e = q[0];
        vectors++; if ({out_sel, out_EA, out_EB, out_err} !== {e.sel, e.ea, e.eb, e.err})
          begin miscompares++;
          $display("FAIL rnd_data c%0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc, out_sel,
                   out_EA, out_EB, out_err, e.sel, e.ea, e.eb, e.err);
        end
      end else begin
        vectors++; if (out_err !== 2'b00) begin miscompares++;
          $display("FAIL rnd_empty_err c%0d: got %b want 00", cyc, out_err); end
      end
      k = $urandom_range(0, 15);
      if (k < 8) begin in_op = 6'h00; in_funct = fn_tab[k]; end
      else if (k < 15) begin in_op = op_tab[k - 8]; in_funct = 6'($urandom); end
      else begin in_op = 6'($urandom); in_funct = 6'($urandom); end
      in_rs_val = $urandom;
      in_rt_val = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      in_imm    = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      acc = in_valid && (q.size() < 2) && !flush;
      drn = (q.size() > 0) && out_ready;
      if (drn) begin void'(q.pop_front()); exp_cnt++; end
      if (acc) q.push_back(model(in_op, in_funct, in_rs_val, in_rt_val, in_imm));
      if (flush) q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    if (q.size() > 0) exp_cnt++;
    q.delete();
    repeat (2) @(negedge clk);
    vectors++; if ({out_valid, issued_cnt} !== {1'b0, exp_cnt}) begin miscompares++;
      $display("FAIL rnd_final: got v=%b cnt=%0d want 0/%0d", out_valid, issued_cnt,
               exp_cnt); end
  endtask

  task automatic test_wrap;
    int remaining;
    remaining = 32'hFFFF - int'(exp_cnt);
    out_ready = 1'b1;
    if (remaining > 0) begin
      drive(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
      repeat (remaining) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    exp_cnt = 16'hFFFF;
    vectors++; if ({out_valid, issued_cnt} !== {1'b0, 16'hFFFF}) begin miscompares++;
      $display("FAIL wrap_preload: got v=%b cnt=%h want 0/ffff", out_valid, issued_cnt); end
    drive(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    exp_cnt++;
    vectors++; if (issued_cnt !== 16'h0000) begin miscompares++;
      $display("FAIL wrap_zero: got %h want 0000", issued_cnt); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive(6'h00, 6'h25, 32'h77, 32'h88, 16'h0);
    @(negedge clk);
    drive(6'h00, 6'h25, 32'h99, 32'h88, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({out_valid, in_ready, out_EA, out_EB, out_sel, out_err, issued_cnt} !==
                   {1'b0, 1'b1, 86'd0}) begin miscompares++;
      $display("FAIL async_reset: got v=%b rdy=%b EA=%h EB=%h sel=%h err=%b cnt=%h want 0/1/0",
               out_valid, in_ready, out_EA, out_EB, out_sel, out_err, issued_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({out_valid, issued_cnt} !== {1'b0, 16'd0}) begin miscompares++;
      $display("FAIL async_reset_lost: got v=%b cnt=%0d want 0/0", out_valid, issued_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_errors();
    test_back_to_back();
    test_flush();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered operand-issue stage sitting directly upstream of the 32-bit ALU. It takes decoded instruction fields plus register-file read values and presents registered EA, EB and sel to the ALU.
- Maps MIPS opcode/funct to the ALU's 4-bit sel encoding, selects immediate versus register for EB, and flags illegal ops and divide-by-zero.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so that backpressure from the execute side never drops an instruction.

Parameters:
- DW, 32, operand width (only 32 is supported; it must match the ALU).
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  clock (rising edge)
- rst_n  in  1  asynchronous reset, active low
- flush  in  1  synchronous flush; discards all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_op  in  6  opcode
- in_funct  in  6  funct field (used when in_op==0)
- in_rs_val  in  DW  rs register value
- in_rt_val  in  DW  rt register value
- in_imm  in  16  immediate
- out_valid  out  1  EA/EB/sel valid toward the ALU
- out_ready  in  1  execute side accepts
- out_EA  out  DW  ALU operand A
- out_EB  out  DW  ALU operand B
- out_sel  out  4  ALU select
- out_err  out  2  bit0 illegal op, bit1 divide by zero
- issued_cnt  out  CNT_W  count of entries accepted downstream

Behaviour:
- Reset: all outputs 0, except in_ready=1. Both buffer entries are invalid and issued_cnt=0. Reset is asynchronous and may assert mid-transfer; any in-flight entry is lost.
- Decode, with EA=in_rs_val unless stated:
  - op 0, funct 0x20 -> sel 0; 0x22 -> 1; 0x24 -> 2; 0x25 -> 3; 0x2A -> 4; 0x21 (move) -> 5; 0x18 -> 6; 0x1A -> 7. For all of these, EB=in_rt_val.
  - op 0x08 addi -> sel 0, EB = sign-extended imm.
  - op 0x0A slti -> sel 4, EB = sign-extended imm.
  - op 0x0C andi -> sel 2, EB = zero-extended imm.
  - op 0x0D ori -> sel 3, EB = zero-extended imm.
  - op 0x04 beq -> sel 1, EB=in_rt_val.
  - op 0x05 bne -> sel 8, EB=in_rt_val.
  - op 0x07 bgtz -> sel 9, EB=0.
  - Anything else -> sel 4'hF, EA=EB=0, err[0]=1.
- Divide by zero: sel 7 with in_rt_val==0 sets err[1]=1 and forces EB=1, so the ALU never sees an X result.
- Decode is combinational on the input side; results are captured into the buffer on accept (in_valid && in_ready).
- Buffer: main register M drives the outputs; skid register S.
  - Accept while M is empty, or while M drains in the same cycle -> the entry goes to M.
  - Accept while M is full and not draining -> the entry goes to S.
  - When M drains and S is valid, S moves to M.
- in_ready is registered and equals !S.valid.
- Latency: input to output is 1 cycle. Sustained throughput is 1 entry/cycle while out_ready=1.
- Drain: out_valid && out_ready; issued_cnt increments on each drain and wraps from 2^CNT_W-1 to 0.
- Output hold: out_* stays stable while out_valid=1 and out_ready=0.
- Full: with both M and S valid, in_ready=0 and in_valid is ignored.
- flush: both entries are cleared next cycle, out_valid=0, in_ready=1. A simultaneous accept is discarded. issued_cnt still counts a drain that occurs in the flush cycle.
- Empty: out_valid=0. out_EA, out_EB and out_sel hold their last values; out_err=0.

Decomposition:
- Shared package holds:
  - ALU sel constants (SEL_ADD=0 … SEL_BGTZ=9, SEL_ILL=15).
  - Opcode and funct constants.
  - The error-bit indices.
- Sub-module alu_op_decode: combinational opcode/funct -> {sel, imm_mode, err}. The buffer logic stays in the top module.

Test Plan:
- Reset then in_valid=1 with op0/funct 0x20, rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, EA=5, EB=7, sel=0, err=0, and issued_cnt=1 after the drain.
- addi with imm=16'hFFFE and rs=3 -> EB=32'hFFFFFFFE, sel=0. ori with imm=16'h8001 -> EB=32'h00008001, sel=3.
- div, rt=0 -> sel=7, EB=1, err=2'b10. opcode 0x3F -> sel=15, err=2'b01.
- out_ready=0 with three back-to-back entries A, B, C -> A is held in M, B goes to S, in_ready=0 and C is not taken. Raising out_ready then yields A, B, C in order with no loss or duplicates.
- Both entries full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and nothing is issued.
- Preload issued_cnt to 16'hFFFF via drains, then one more drain -> issued_cnt=0. Asserting rst_n=0 mid-stream clears the outputs asynchronously, with no clock edge needed.
